// File: rtl/rename_regfile_mp_pkg.sv
// Shared constants and bus-slicing helpers for the multi-port renaming register file.
package rename_regfile_mp_pkg;

  localparam int unsigned DEF_NREG = 32;
  localparam int unsigned DEF_XLEN = 32;
  localparam int unsigned DEF_TAGW = 4;
  localparam int unsigned DEF_NWB  = 2;
  localparam int unsigned DEF_NRD  = 2;

  // Free tag is all-ones at any width; data resets to all-zeros.
  localparam logic TAG_FREE_BIT  = 1'b1;
  localparam logic DATA_FREE_BIT = 1'b0;
  localparam logic [DEF_TAGW-1:0] TAG_FREE = '1;

  function automatic int unsigned lsb(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/rename_regfile_mp_if.sv
// Write-back, rename, flush and read-port bundle of the renaming register file.
interface rename_regfile_mp_if
  import rename_regfile_mp_pkg::*;
#(
  parameter int unsigned NREG  = DEF_NREG,
  parameter int unsigned XLEN  = DEF_XLEN,
  parameter int unsigned TAGW  = DEF_TAGW,
  parameter int unsigned NWB   = DEF_NWB,
  parameter int unsigned NRD   = DEF_NRD,
  parameter int unsigned NAMEW = $clog2(NREG)
);
  logic [NWB-1:0]       wb_en;
  logic [NWB*NAMEW-1:0] wb_name;
  logic [NWB*TAGW-1:0]  wb_tag;
  logic [NWB*XLEN-1:0]  wb_data;
  logic                 ren_en;
  logic [NAMEW-1:0]     ren_name;
  logic [TAGW-1:0]      ren_tag;
  logic                 flush;
  logic [NRD*NAMEW-1:0] rd_name;
  logic [NRD*XLEN-1:0]  rd_data;
  logic [NRD*TAGW-1:0]  rd_tag;
  logic [NAMEW:0]       busy_cnt;

  modport master (
    output wb_en, wb_name, wb_tag, wb_data, ren_en, ren_name, ren_tag, flush, rd_name,
    input  rd_data, rd_tag, busy_cnt
  );

  modport slave (
    input  wb_en, wb_name, wb_tag, wb_data, ren_en, ren_name, ren_tag, flush, rd_name,
    output rd_data, rd_tag, busy_cnt
  );

endinterface

// File: rtl/rename_regfile_mp_wb_select.sv
// Lowest-index write-back channel selector for one register name.
module rename_regfile_mp_wb_select
  import rename_regfile_mp_pkg::*;
#(
  parameter int unsigned NWB       = DEF_NWB,
  parameter int unsigned NAMEW     = 5,
  parameter int unsigned TAGW      = DEF_TAGW,
  parameter int unsigned XLEN      = DEF_XLEN,
  parameter bit          MATCH_TAG = 1'b1
) (
  input  logic [NWB-1:0]       wb_en,
  input  logic [NWB*NAMEW-1:0] wb_name,
  input  logic [NWB*TAGW-1:0]  wb_tag,
  input  logic [NWB*XLEN-1:0]  wb_data,
  input  logic [NAMEW-1:0]     name,
  input  logic [TAGW-1:0]      tag,
  output logic                 hit,
  output logic                 tag_eq,
  output logic [XLEN-1:0]      data
);

  // MATCH_TAG=1 selects the bypass source, MATCH_TAG=0 the write winner by name only.
  always_comb begin
    hit    = 1'b0;
    tag_eq = 1'b0;
    data   = '0;
    for (int unsigned k = 0; k < NWB; k++) begin
      if (!hit && wb_en[k] && (wb_name[lsb(k, NAMEW) +: NAMEW] == name) &&
          (!MATCH_TAG || (wb_tag[lsb(k, TAGW) +: TAGW] == tag))) begin
        hit    = 1'b1;
        tag_eq = (wb_tag[lsb(k, TAGW) +: TAGW] == tag);
        data   = wb_data[lsb(k, XLEN) +: XLEN];
      end
    end
  end

endmodule

// File: rtl/rename_regfile_mp.sv
// Multi-port renaming register file: NWB write-backs, NRD bypassed reads, flush, busy count.
module rename_regfile_mp
  import rename_regfile_mp_pkg::*;
#(
  parameter int unsigned NREG  = DEF_NREG,
  parameter int unsigned XLEN  = DEF_XLEN,
  parameter int unsigned TAGW  = DEF_TAGW,
  parameter int unsigned NWB   = DEF_NWB,
  parameter int unsigned NRD   = DEF_NRD,
  parameter int unsigned NAMEW = $clog2(NREG)
) (
  input logic                clk,
  input logic                rst_n,
  rename_regfile_mp_if.slave bus
);

  localparam logic [TAGW-1:0] TFREE = {TAGW{TAG_FREE_BIT}};
  localparam logic [XLEN-1:0] DFREE = {XLEN{DATA_FREE_BIT}};

  logic [XLEN-1:0] data_q  [NREG];
  logic [TAGW-1:0] tag_q   [NREG];
  logic [TAGW-1:0] tag_nxt [1:NREG-1];
  logic [NREG-1:1] busy_vec;
  logic [NAMEW:0]  busy_q;
  logic [NAMEW:0]  busy_nxt;

  generate
    for (genvar r = 0; r < NREG; r++) begin : g_reg
      if (r == 0) begin : g_x0
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            data_q[0] <= DFREE;
            tag_q[0]  <= TFREE;
          end else begin
            data_q[0] <= DFREE;
            tag_q[0]  <= TFREE;
          end
        end
      end else begin : g_xn
        logic            w_hit;
        logic            w_teq;
        logic [XLEN-1:0] w_data;
        logic            ren_hit;

        rename_regfile_mp_wb_select #(
          .NWB(NWB), .NAMEW(NAMEW), .TAGW(TAGW), .XLEN(XLEN), .MATCH_TAG(1'b0)
        ) u_wsel (
          .wb_en(bus.wb_en), .wb_name(bus.wb_name), .wb_tag(bus.wb_tag), .wb_data(bus.wb_data),
          .name(NAMEW'(r)), .tag(tag_q[r]),
          .hit(w_hit), .tag_eq(w_teq), .data(w_data)
        );

        // Priority: flush > rename > write-back clear; a losing channel never clears.
        assign ren_hit     = bus.ren_en && (bus.ren_name == NAMEW'(r));
        assign tag_nxt[r]  = bus.flush         ? TFREE       :
                             ren_hit           ? bus.ren_tag :
                             (w_hit && w_teq)  ? TFREE       : tag_q[r];
        assign busy_vec[r] = (tag_nxt[r] != TFREE);

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            data_q[r] <= DFREE;
            tag_q[r]  <= TFREE;
          end else begin
            if (w_hit) data_q[r] <= w_data;
            tag_q[r] <= tag_nxt[r];
          end
        end
      end
    end
  endgenerate

  assign busy_nxt = (NAMEW+1)'($countones(busy_vec));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_nxt;
  end

  assign bus.busy_cnt = busy_q;

  generate
    for (genvar j = 0; j < NRD; j++) begin : g_rd
      logic [NAMEW-1:0] n;
      logic             b_hit;
      logic             b_teq;
      logic [XLEN-1:0]  b_data;
      logic [XLEN-1:0]  d;
      logic [TAGW-1:0]  t;

      assign n = bus.rd_name[j*NAMEW +: NAMEW];

      rename_regfile_mp_wb_select #(
        .NWB(NWB), .NAMEW(NAMEW), .TAGW(TAGW), .XLEN(XLEN), .MATCH_TAG(1'b1)
      ) u_bsel (
        .wb_en(bus.wb_en), .wb_name(bus.wb_name), .wb_tag(bus.wb_tag), .wb_data(bus.wb_data),
        .name(n), .tag(tag_q[n]),
        .hit(b_hit), .tag_eq(b_teq), .data(b_data)
      );

      // Reset gating keeps a live write-back from leaking through the bypass.
      always_comb begin
        d = DFREE;
        t = TFREE;
        if (rst_n && (n != '0)) begin
          if (b_hit && b_teq) begin
            d = b_data;
          end else begin
            d = data_q[n];
            t = tag_q[n];
          end
        end
      end

      assign bus.rd_data[j*XLEN +: XLEN] = d;
      assign bus.rd_tag[j*TAGW +: TAGW]  = t;
    end
  endgenerate

endmodule

// File: tb/tb_rename_regfile_mp.sv
// Bench for rename_regfile_mp: directed vector table, random run against a reference model, mid-run reset.
module tb_rename_regfile_mp;

  localparam logic [3:0] F = 4'hF;

  logic clk;
  logic rst_n;
  int   ncmp;
  int   nerr;

  rename_regfile_mp_if #(.NREG(32), .XLEN(32), .TAGW(4), .NWB(2), .NRD(2)) bus ();

  rename_regfile_mp #(.NREG(32), .XLEN(32), .TAGW(4), .NWB(2), .NRD(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ren_en;
    logic [4:0]  ren_name;
    logic [3:0]  ren_tag;
    logic        flush;
    logic [1:0]  wb_en;
    logic [4:0]  wn0;
    logic [3:0]  wt0;
    logic [31:0] wd0;
    logic [4:0]  wn1;
    logic [3:0]  wt1;
    logic [31:0] wd1;
    logic [4:0]  rn0;
    logic [4:0]  rn1;
    logic [31:0] ed0;
    logic [3:0]  et0;
    logic [31:0] ed1;
    logic [3:0]  et1;
    logic [5:0]  eb;
  } vec_t;

  vec_t vecs[21];

  // Reference state: architectural data and tag per register name.
  logic [31:0] dm[32];
  logic [3:0]  tm[32];

  function automatic vec_t mk(
    input logic re, input logic [4:0] rn, input logic [3:0] rt, input logic fl,
    input logic [1:0] we,
    input logic [4:0] n0, input logic [3:0] t0, input logic [31:0] d0,
    input logic [4:0] n1, input logic [3:0] t1, input logic [31:0] d1,
    input logic [4:0] r0, input logic [4:0] r1,
    input logic [31:0] e0, input logic [3:0] g0,
    input logic [31:0] e1, input logic [3:0] g1, input logic [5:0] b);
    vec_t v;
    v.ren_en = re; v.ren_name = rn; v.ren_tag = rt; v.flush = fl; v.wb_en = we;
    v.wn0 = n0; v.wt0 = t0; v.wd0 = d0; v.wn1 = n1; v.wt1 = t1; v.wd1 = d1;
    v.rn0 = r0; v.rn1 = r1; v.ed0 = e0; v.et0 = g0; v.ed1 = e1; v.et1 = g1; v.eb = b;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.ren_en   = v.ren_en;
    bus.ren_name = v.ren_name;
    bus.ren_tag  = v.ren_tag;
    bus.flush    = v.flush;
    bus.wb_en    = v.wb_en;
    bus.wb_name  = {v.wn1, v.wn0};
    bus.wb_tag   = {v.wt1, v.wt0};
    bus.wb_data  = {v.wd1, v.wd0};
    bus.rd_name  = {v.rn1, v.rn0};
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic mreset();
    for (int i = 0; i < 32; i++) begin
      dm[i] = '0;
      tm[i] = F;
    end
  endtask

  function automatic int mbusy();
    int c;
    c = 0;
    for (int i = 1; i < 32; i++) if (tm[i] != F) c++;
    return c;
  endfunction

  // Operand as the specification defines it: x0 is constant, else matching write-back wins.
  task automatic mread(input logic [4:0] n, output logic [31:0] d, output logic [3:0] t);
    logic [1:0]  en;
    logic [9:0]  nm;
    logic [7:0]  tg;
    logic [63:0] dt;
    logic        found;
    en = bus.wb_en; nm = bus.wb_name; tg = bus.wb_tag; dt = bus.wb_data;
    d = '0;
    t = F;
    found = 1'b0;
    if (n != 5'd0) begin
      d = dm[n];
      t = tm[n];
      for (int k = 0; k < 2; k++) begin
        if (!found && en[k] && nm[k*5 +: 5] == n && tg[k*4 +: 4] == tm[n]) begin
          found = 1'b1;
          d = dt[k*32 +: 32];
          t = F;
        end
      end
    end
  endtask

  // Edge update from the current inputs.
  task automatic mstep();
    logic [31:0] nd[32];
    logic [3:0]  nt[32];
    bit          claimed[32];
    logic [1:0]  en;
    logic [9:0]  nm;
    logic [7:0]  tg;
    logic [63:0] dt;
    logic [4:0]  n;
    en = bus.wb_en; nm = bus.wb_name; tg = bus.wb_tag; dt = bus.wb_data;
    nd = dm;
    nt = tm;
    for (int i = 0; i < 32; i++) claimed[i] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n = nm[k*5 +: 5];
      if (en[k] && n != 5'd0 && !claimed[n]) begin
        claimed[n] = 1'b1;
        nd[n] = dt[k*32 +: 32];
        if (tg[k*4 +: 4] == tm[n] && !(bus.ren_en && bus.ren_name == n)) nt[n] = F;
      end
    end
    if (bus.ren_en && bus.ren_name != 5'd0) nt[bus.ren_name] = bus.ren_tag;
    if (bus.flush) for (int i = 0; i < 32; i++) nt[i] = F;
    nt[0] = F;
    dm = nd;
    tm = nt;
  endtask

  task automatic rcycle(input string tagname);
    logic [31:0] d0, d1;
    logic [3:0]  t0, t1;
    @(negedge clk);
    mread(bus.rd_name[4:0], d0, t0);
    mread(bus.rd_name[9:5], d1, t1);
    check({tagname, " rd0_data"}, bus.rd_data[31:0], d0);
    check({tagname, " rd0_tag"}, {28'd0, bus.rd_tag[3:0]}, {28'd0, t0});
    check({tagname, " rd1_data"}, bus.rd_data[63:32], d1);
    check({tagname, " rd1_tag"}, {28'd0, bus.rd_tag[7:4]}, {28'd0, t1});
    check({tagname, " busy_cnt"}, {26'd0, bus.busy_cnt}, 32'(mbusy()));
    @(posedge clk);
    mstep();
    #1;
  endtask

  initial begin
    vec_t        v;
    logic [4:0]  n0, n1;
    ncmp = 0;
    nerr = 0;

    //        ren nm tg fl  wb     n0 t0 d0           n1 t1 d1            r0 r1  ed0          et0 ed1           et1 busy
    vecs[0]  = mk(0, 0, 0, 0, 2'b00, 0, 0, 0,         0, 0, 0,            5, 0,  0,           F,  0,            F,  0);
    vecs[1]  = mk(1, 3, 2, 0, 2'b00, 0, 0, 0,         0, 0, 0,            3, 0,  0,           F,  0,            F,  0);
    vecs[2]  = mk(0, 0, 0, 0, 2'b00, 0, 0, 0,         0, 0, 0,            3, 5,  0,           2,  0,            F,  1);
    vecs[3]  = mk(0, 0, 0, 0, 2'b10, 0, 0, 0,         3, 2, 32'hDEAD,     3, 3,  32'hDEAD,    F,  32'hDEAD,     F,  1);
    vecs[4]  = mk(0, 0, 0, 0, 2'b00, 0, 0, 0,         0, 0, 0,            3, 0,  32'hDEAD,    F,  0,            F,  0);
    vecs[5]  = mk(1, 4, 1, 0, 2'b00, 0, 0, 0,         0, 0, 0,            4, 0,  0,           F,  0,            F,  0);
    vecs[6]  = mk(1, 4, 6, 0, 2'b00, 0, 0, 0,         0, 0, 0,            4, 0,  0,           1,  0,            F,  1);
    vecs[7]  = mk(0, 0, 0, 0, 2'b01, 4, 1, 32'h11,    0, 0, 0,            4, 0,  0,           6,  0,            F,  1);
    vecs[8]  = mk(0, 0, 0, 0, 2'b00, 0, 0, 0,         0, 0, 0,            4, 0,  32'h11,      6,  0,            F,  1);
    vecs[9]  = mk(1, 7, 3, 0, 2'b00, 0, 0, 0,         0, 0, 0,            7, 4,  0,           F,  32'h11,       6,  1);
    vecs[10] = mk(1, 7, 5, 0, 2'b01, 7, 3, 32'hAA,    0, 0, 0,            7, 4,  32'hAA,      F,  32'h11,       6,  2);
    vecs[11] = mk(0, 0, 0, 0, 2'b11, 7, 0, 32'h1,     7, 0, 32'h2,        7, 7,  32'hAA,      5,  32'hAA,       5,  2);
    vecs[12] = mk(0, 0, 0, 0, 2'b00, 0, 0, 0,         0, 0, 0,            7, 4,  32'h1,       5,  32'h11,       6,  2);
    vecs[13] = mk(0, 0, 0, 1, 2'b00, 0, 0, 0,         0, 0, 0,            7, 4,  32'h1,       5,  32'h11,       6,  2);
    vecs[14] = mk(1, 1, 7, 0, 2'b00, 0, 0, 0,         0, 0, 0,            7, 4,  32'h1,       F,  32'h11,       F,  0);
    vecs[15] = mk(1, 2, 8, 0, 2'b00, 0, 0, 0,         0, 0, 0,            1, 2,  0,           7,  0,            F,  1);
    vecs[16] = mk(1, 9, 9, 0, 2'b00, 0, 0, 0,         0, 0, 0,            2, 9,  0,           8,  0,            F,  2);
    vecs[17] = mk(1, 10, 4, 1, 2'b00, 0, 0, 0,        0, 0, 0,            9, 10, 0,           9,  0,            F,  3);
    vecs[18] = mk(0, 0, 0, 0, 2'b00, 0, 0, 0,         0, 0, 0,            10, 9, 0,           F,  0,            F,  0);
    vecs[19] = mk(1, 0, 2, 0, 2'b01, 0, F, 32'h55,    0, 0, 0,            0, 0,  0,           F,  0,            F,  0);
    vecs[20] = mk(0, 0, 0, 0, 2'b00, 0, 0, 0,         0, 0, 0,            0, 3,  0,           F,  32'hDEAD,     F,  0);

    // Reset with a live write-back aimed at the read name: outputs must stay 0/F.
    rst_n = 1'b0;
    mreset();
    drive(mk(0, 0, 0, 0, 2'b01, 5, F, 32'h1234, 0, 0, 0, 5, 0, 0, F, 0, F, 0));
    repeat (2) @(posedge clk);
    #2;
    check("reset rd0_data", bus.rd_data[31:0], 32'd0);
    check("reset rd0_tag", {28'd0, bus.rd_tag[3:0]}, {28'd0, F});
    check("reset rd1_tag", {28'd0, bus.rd_tag[7:4]}, {28'd0, F});
    check("reset busy_cnt", {26'd0, bus.busy_cnt}, 32'd0);
    drive(vecs[0]);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      drive(vecs[i]);
      @(negedge clk);
      check($sformatf("vec%0d rd0_data", i), bus.rd_data[31:0], vecs[i].ed0);
      check($sformatf("vec%0d rd0_tag", i), {28'd0, bus.rd_tag[3:0]}, {28'd0, vecs[i].et0});
      check($sformatf("vec%0d rd1_data", i), bus.rd_data[63:32], vecs[i].ed1);
      check($sformatf("vec%0d rd1_tag", i), {28'd0, bus.rd_tag[7:4]}, {28'd0, vecs[i].et1});
      check($sformatf("vec%0d busy_cnt", i), {26'd0, bus.busy_cnt}, {26'd0, vecs[i].eb});
      @(posedge clk);
      mstep();
      #1;
    end

    // Random traffic on a narrow name range so collisions and tag hits are frequent.
    for (int c = 0; c < 600; c++) begin
      n0 = 5'($urandom_range(0, 7));
      n1 = 5'($urandom_range(0, 7));
      v = mk(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
             ($urandom_range(0, 31) == 0),
             2'($urandom_range(0, 3)),
             n0, ($urandom_range(0, 1) != 0) ? tm[n0] : 4'($urandom_range(0, 15)), $urandom(),
             n1, ($urandom_range(0, 1) != 0) ? tm[n1] : 4'($urandom_range(0, 15)), $urandom(),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             0, 0, 0, 0, 0);
      drive(v);
      rcycle($sformatf("rand%0d", c));
    end

    // Mid-run reset must drop pending renames and gate the bypass at once.
    drive(mk(1, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0, 0, 5, 6, 0, 0, 0, 0, 0));
    rcycle("pre flush");
    drive(mk(1, 5, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 5, 6, 0, 0, 0, 0, 0));
    rcycle("pre ren5");
    drive(mk(1, 6, 2, 0, 2'b00, 0, 0, 0, 0, 0, 0, 5, 6, 0, 0, 0, 0, 0));
    rcycle("pre ren6");
    drive(mk(0, 0, 0, 0, 2'b01, 5, 1, 32'h77, 0, 0, 0, 5, 6, 0, 0, 0, 0, 0));
    #1;
    check("prereset bypass data", bus.rd_data[31:0], 32'h77);
    check("prereset busy_cnt", {26'd0, bus.busy_cnt}, 32'd2);
    #1;
    rst_n = 1'b0;
    #1;
    mreset();
    check("midreset rd0_data", bus.rd_data[31:0], 32'd0);
    check("midreset rd0_tag", {28'd0, bus.rd_tag[3:0]}, {28'd0, F});
    check("midreset rd1_tag", {28'd0, bus.rd_tag[7:4]}, {28'd0, F});
    check("midreset busy_cnt", {26'd0, bus.busy_cnt}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 5, 6, 0, 0, 0, 0, 0));
    rcycle("postreset0");
    rcycle("postreset1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/rename_regfile_mp.md
Name: rename_regfile_mp

Overview:
- Multi-port, parametrised successor of the renaming register file in the Tomasulo core.
- Holds architectural data plus a rename tag per register.
- Accepts NWB write-back channels (ALU, LS, and further units) and serves NRD source-operand reads with same-cycle bypass.
- Adds a misprediction flush that frees all tags, hard-wires x0, and keeps a live count of busy (renamed) registers for the dispatcher.

Parameters:
- NREG, 32, number of architectural registers (power of 2).
- XLEN, 32, data width.
- TAGW, 4, rename tag width.
- NWB, 2, write-back channels.
- NRD, 2, read ports.
- NAMEW, $clog2(NREG), register name width (derived).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- wb_en  in  NWB  write-back valid, one bit per channel.
- wb_name  in  NWB*NAMEW  destination names, channel k at [k*NAMEW +: NAMEW].
- wb_tag  in  NWB*TAGW  producer tags.
- wb_data  in  NWB*XLEN  results.
- ren_en  in  1  dispatcher rename request.
- ren_name  in  NAMEW  register being renamed.
- ren_tag  in  TAGW  new producer tag.
- flush  in  1  misprediction: free all tags.
- rd_name  in  NRD*NAMEW  read names.
- rd_data  out  NRD*XLEN  operand value.
- rd_tag  out  NRD*TAGW  TAG_FREE when the value is ready, otherwise the pending producer tag.
- busy_cnt  out  NAMEW+1  count of registers whose tag is not TAG_FREE (registered).

Behaviour:
- Reset (rst_n low, asynchronous): all data set to DATA_FREE (0), all tags set to TAG_FREE, busy_cnt = 0. While reset is asserted, every rd_data = 0 and every rd_tag = TAG_FREE. A reset asserted mid-operation discards all pending renames immediately.
- x0: reads return 0 / TAG_FREE. Write-back and rename to name 0 are ignored. Excluded from busy_cnt.
- Write-back, channel k, per clock edge:
  - data[wb_name_k] <= wb_data_k unconditionally when wb_en_k.
  - tag[wb_name_k] <= TAG_FREE only if wb_tag_k == tag[wb_name_k] (current stored tag) AND NOT (ren_en && ren_name == wb_name_k).
  - A stale tag (older producer) updates data but leaves the tag unchanged.
- Same-name collision between channels: the lowest channel index wins both data and tag action; higher channels to that name are dropped that cycle. Software/scheduler guarantees this only happens with stale producers.
- Rename: ren_en sets tag[ren_name] <= ren_tag. Rename beats any same-cycle write-back clear on that name.
- Flush: all tags <= TAG_FREE at the edge. Flush overrides a same-cycle rename. Same-cycle write-back data is still written.
- Read (combinational, 0 latency), for port j with name n:
  - If some wb_en_k with wb_name_k == n and wb_tag_k == tag[n], the lowest such k supplies rd_data = wb_data_k and rd_tag = TAG_FREE.
  - Otherwise rd_data = data[n], rd_tag = tag[n].
  - Same-cycle ren_en is NOT visible to reads; the dispatcher resolves intra-bundle dependencies itself.
  - Same-cycle flush is NOT visible to reads.
- busy_cnt is registered and equals the popcount of the next-state tag vector (names 1..NREG-1). It updates one cycle after the causing event and reads 0 the cycle after a flush.
- Tags in TAG_FREE encoding are never issued by the dispatcher; ren_tag == TAG_FREE is treated as a rename to free.

Decomposition:
- Package rf_pkg: TAG_FREE = {TAGW{1'b1}}, DATA_FREE = 0, default widths, and helper functions for flattened-bus slicing.
- One sub-module, rf_wb_select: given a name and the stored tag, returns hit / data / index from the NWB channels using lowest-index priority. Instantiated once per read port and reused for the write-back collision resolution.

Test Plan:
- Reset then read x5 and x0 -> rd_data 0, rd_tag TAG_FREE (4'hF); busy_cnt 0; assert rst_n low mid-run after renames -> outputs 0/F immediately, busy_cnt 0.
- Rename x3 to tag 2; next cycle rd x3 -> tag 2, busy_cnt 1; wb ch1 {x3, tag 2, 0xDEAD} with same-cycle rd x3 -> rd_data 0xDEAD, rd_tag F; next cycle stored tag F, busy_cnt 0.
- Rename x4 to tag 1, then rename x4 to tag 6; wb ch0 {x4, tag 1, 0x11} -> data 0x11 written, tag stays 6, rd x4 tag 6.
- Same cycle: wb ch0 {x7, tag 3, 0xAA} clears, ren {x7, tag 5} -> tag[x7] = 5; wb ch0 and ch1 both to x7 with data 0x1 / 0x2 -> data 0x1.
- Rename x1, x2, x9 (busy_cnt 3), then flush with concurrent ren x10 tag 4 -> all tags F, busy_cnt 0 the following cycle.
- wb to x0 with 0x55 and ren x0 tag 2 -> rd x0 returns 0/F, busy_cnt unchanged.
